// File: rtl/cgra_ker_scheduler.sv
// Kernel scheduler in front of the CGRA controller: round-robin arbitration of
// kernel requests over free columns, one configuration handshake at a time.
package cgra_pkg;
  localparam int N_COL               = 4;
  localparam int KER_CONF_N_REG_LOG2 = 4;
endpackage

module cgra_ker_scheduler
  import cgra_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_REQ-1:0]                   req_valid_i,
  input  logic [N_REQ*KER_CONF_N_REG_LOG2-1:0] req_ker_id_i,
  input  logic [N_REQ*N_COL-1:0]             req_col_mask_i,
  output logic [N_REQ-1:0]                   req_ready_o,
  output logic [N_REQ-1:0]                   done_o,
  output logic [N_COL-1:0]                   acc_req_o,
  output logic [KER_CONF_N_REG_LOG2-1:0]     ker_id_o,
  input  logic                               acc_ack_i,
  input  logic [N_COL-1:0]                   acc_end_i,
  output logic [N_COL-1:0]                   col_busy_o,
  output logic                               err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int KW    = KER_CONF_N_REG_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_q;
  logic [N_COL-1:0] lat_mask;
  logic [KW-1:0]    ker_id_q;
  logic [N_COL-1:0] col_busy;
  logic [N_REQ-1:0] active;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic [N_COL-1:0] pend_mask [N_REQ];
  logic [IDX_W-1:0] owner [N_COL];

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] zr_cand;
  logic             any_elig;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [N_COL-1:0] gnt_mask;
  logic [KW-1:0]    gnt_kid;
  logic             zr_any;
  logic [IDX_W-1:0] zr_idx;
  logic             zr_fire;
  logic             issue_ack;
  logic [N_COL-1:0] valid_end;
  logic [N_COL-1:0] col_busy_nxt;
  logic [N_COL-1:0] pend_nxt [N_REQ];
  logic [N_REQ-1:0] active_nxt;
  logic [N_REQ-1:0] done_nxt;
  logic             err_nxt;

  // Eligibility uses the registered busy map, so a same-cycle end never sways a grant.
  always_comb begin
    elig    = '0;
    zr_cand = '0;
    for (int r = 0; r < N_REQ; r++) begin
      elig[r]    = req_valid_i[r] & ~active[r]
                 & (|req_col_mask_i[r*N_COL +: N_COL])
                 & ~(|(req_col_mask_i[r*N_COL +: N_COL] & col_busy));
      zr_cand[r] = req_valid_i[r] & ~active[r] & ~(|req_col_mask_i[r*N_COL +: N_COL]);
    end
  end

  always_comb begin
    any_elig = 1'b0;
    gnt_idx  = '0;
    rr_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rr_idx = (int'(rr_ptr) + k >= N_REQ) ? IDX_W'(int'(rr_ptr) + k - N_REQ)
                                           : IDX_W'(int'(rr_ptr) + k);
      if (!any_elig && elig[rr_idx]) begin
        any_elig = 1'b1;
        gnt_idx  = rr_idx;
      end
    end
  end

  always_comb begin
    gnt_mask = '0;
    gnt_kid  = '0;
    zr_any   = 1'b0;
    zr_idx   = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (gnt_idx == IDX_W'(r)) begin
        gnt_mask = req_col_mask_i[r*N_COL +: N_COL];
        gnt_kid  = req_ker_id_i[r*KW +: KW];
      end
    end
    for (int r = N_REQ - 1; r >= 0; r--) begin
      if (zr_cand[r]) begin
        zr_any = 1'b1;
        zr_idx = IDX_W'(r);
      end
    end
  end

  assign issue_ack = (state == S_ISSUE) & acc_ack_i;
  // Zero-mask requests never touch the controller; they complete on the spot.
  assign zr_fire   = (state == S_IDLE) & ~any_elig & zr_any;

  always_comb begin
    req_ready_o = '0;
    if (!rst_i) begin
      if (issue_ack) begin
        req_ready_o[grant_q] = 1'b1;
      end else if (zr_fire) begin
        req_ready_o[zr_idx] = 1'b1;
      end
    end
  end

  assign valid_end    = acc_end_i & col_busy;
  assign col_busy_nxt = (col_busy & ~valid_end) | (issue_ack ? lat_mask : '0);
  assign err_nxt      = err_q | (|(acc_end_i & ~col_busy))
                      | (acc_ack_i & (state != S_ISSUE));

  // Column ends are routed back to their owners; an emptied pend_mask retires the kernel.
  always_comb begin
    active_nxt = '0;
    done_nxt   = '0;
    for (int r = 0; r < N_REQ; r++) begin
      pend_nxt[r] = pend_mask[r];
      for (int c = 0; c < N_COL; c++) begin
        if (valid_end[c] && (owner[c] == IDX_W'(r))) begin
          pend_nxt[r][c] = 1'b0;
        end
      end
      done_nxt[r]   = active[r] & (|pend_mask[r]) & ~(|pend_nxt[r]);
      active_nxt[r] = active[r] & ~done_nxt[r];
      if (zr_fire && (zr_idx == IDX_W'(r))) begin
        done_nxt[r] = 1'b1;
      end
      if (issue_ack && (grant_q == IDX_W'(r))) begin
        pend_nxt[r]   = lat_mask;
        active_nxt[r] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_q  <= '0;
      lat_mask <= '0;
      ker_id_q <= '0;
      col_busy <= '0;
      active   <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      for (int r = 0; r < N_REQ; r++) begin
        pend_mask[r] <= '0;
      end
      for (int c = 0; c < N_COL; c++) begin
        owner[c] <= '0;
      end
    end else begin
      col_busy <= col_busy_nxt;
      active   <= active_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
      for (int r = 0; r < N_REQ; r++) begin
        pend_mask[r] <= pend_nxt[r];
      end
      if (issue_ack) begin
        for (int c = 0; c < N_COL; c++) begin
          if (lat_mask[c]) begin
            owner[c] <= grant_q;
          end
        end
      end
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            grant_q  <= gnt_idx;
            lat_mask <= gnt_mask;
            ker_id_q <= gnt_kid;
            rr_ptr   <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (acc_ack_i) begin
            state <= S_GAP;
          end
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign acc_req_o  = (state == S_ISSUE) ? lat_mask : '0;
  assign ker_id_o   = ker_id_q;
  assign col_busy_o = col_busy;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
